// File: rtl/red_pitaya_rst_seq.sv
// red_pitaya_rst_seq: PLL lock supervisor and per-domain reset sequencer.
// Define RST_SEQ_LOSS_CNT_EN to add loss_cnt_o (REL/RUN lock-loss counter).
module red_pitaya_rst_seq #(
  parameter int N_DOM      = 4,
  parameter int RST_CYC    = 16,
  parameter int LOCK_TMO   = 65536,
  parameter int STABLE_CYC = 1024,
  parameter int SEQ_GAP    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked_i,
  output logic             pll_rst_o,
  output logic [N_DOM-1:0] dom_rst_o,
  output logic             ready_o,
  output logic [2:0]       state_o,
  output logic [7:0]       tmo_cnt_o
`ifdef RST_SEQ_LOSS_CNT_EN
  ,
  output logic [15:0]      loss_cnt_o
`endif
);

  localparam int MAX_A = (RST_CYC > LOCK_TMO) ? RST_CYC : LOCK_TMO;
  localparam int MAX_B = (STABLE_CYC > SEQ_GAP) ? STABLE_CYC : SEQ_GAP;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int IW    = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  localparam logic [CW-1:0] RST_END = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TMO_END = CW'(LOCK_TMO - 1);
  localparam logic [CW-1:0] STB_END = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP_END = CW'(SEQ_GAP - 1);
  localparam logic [IW-1:0] IDX_END = IW'(N_DOM - 1);

  typedef enum logic [2:0] {
    PRST   = 3'd0,
    WLOCK  = 3'd1,
    STABLE = 3'd2,
    REL    = 3'd3,
    RUN    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_DOM-1:0] dom_q, dom_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             pll_rst_q, pll_rst_d;
  logic             ready_q, ready_d;
  logic             lk_m_q, lk_s_q;
  logic             loss_ev;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    dom_d   = dom_q;
    tmo_d   = tmo_q;
    loss_ev = 1'b0;
    case (state_q)
      PRST: begin
        if (cnt_q == RST_END) begin
          state_d = WLOCK;
          cnt_d   = '0;
        end
      end
      WLOCK: begin
        if (lk_s_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_END) begin
          state_d = PRST;
          cnt_d   = '0;
          if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
        end
      end
      STABLE: begin
        if (!lk_s_q) begin
          state_d = WLOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_END) begin
          state_d = REL;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = {N_DOM{1'b1}} << 1;
        end
      end
      REL, RUN: begin
        if (!lk_s_q) begin
          // abort: every domain back into reset, PLL re-pulsed
          state_d = PRST;
          cnt_d   = '0;
          dom_d   = '1;
          loss_ev = 1'b1;
        end else if (state_q == REL) begin
          if (idx_q == IDX_END) begin
            state_d = RUN;
            cnt_d   = '0;
          end else if (cnt_q == GAP_END) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            dom_d = dom_q << 1;
          end
        end
      end
      default: begin
        state_d = PRST;
        cnt_d   = '0;
        dom_d   = '1;
      end
    endcase
    pll_rst_d = (state_d == PRST);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PRST;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_q     <= '1;
      tmo_q     <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      lk_m_q    <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_q     <= dom_d;
      tmo_q     <= tmo_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      lk_m_q    <= pll_locked_i;
      lk_s_q    <= lk_m_q;
    end
  end

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [15:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (loss_ev && loss_q != 16'hFFFF) loss_d = loss_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end

  assign loss_cnt_o = loss_q;
`else
  logic unused_loss;
  assign unused_loss = loss_ev;
`endif

  assign pll_rst_o = pll_rst_q;
  assign dom_rst_o = dom_q;
  assign ready_o   = ready_q;
  assign state_o   = state_q;
  assign tmo_cnt_o = tmo_q;

endmodule
